ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 29: number of tracked keys; fixed at 29 by the code table in REQ-011.
REQ-002 SHALL have port CLOCK_50  input  1: sole clock; all logic on its rising edge.
REQ-003 SHALL have port resetn  input  1: one clock; reset asynchronous, active-high; the port keeps the codebase name `resetn` despite its polarity.
REQ-004 SHALL have port rx_data  input  8: PS/2 byte from the PS2 controller, valid when rx_valid=1.
REQ-005 SHALL have port rx_valid  input  1: one-cycle strobe, synchronous to CLOCK_50; never high on two consecutive cycles.
REQ-006 SHALL have port clear  input  1: synchronous clear of all key state and the parser state.
REQ-007 SHALL have port key_state  output  NUM_KEYS: 1 means key currently held.
REQ-008 SHALL have port no_press  output  1: 1 when key_state is all zero.
REQ-009 SHALL have port evt_valid  output  1: one-cycle pulse marking a key state change.
REQ-010 SHALL have port evt_key  output  5 and port evt_make  output  1: index of the changed key; 1 = press, 0 = release.

Function
REQ-011 SHALL use this scancode-to-index map (index:hex): 0:0E 1:16 2:1E 3:26 4:25 5:2E 6:36 7:3D 8:3E 9:46 10:45 11:4E 12:55 13:66 14:0D 15:15 16:1D 17:24 18:2D 19:2C 20:35 21:3C 22:43 23:44 24:4D 25:54 26:5B 27:5D 28:29.
REQ-012 SHALL implement parser FSM states IDLE, BRK, EXT, EXT_BRK, all transitions taken only on cycles with rx_valid=1.
REQ-013 SHALL transition as follows:
- IDLE: on F0 go to BRK; on E0 go to EXT (per REQ-024/025); otherwise decode as a make and stay in IDLE.
- BRK: on F0 stay in BRK; on any other byte decode as a break and go to IDLE.
- EXT: on F0 go to EXT_BRK; on any other byte go to IDLE.
- EXT_BRK: on any byte go to IDLE.
REQ-014 Make of a mapped key whose bit is 0 SHALL set that bit and pulse evt_valid with evt_make=1.
REQ-015 Break of a mapped key whose bit is 1 SHALL clear that bit and pulse evt_valid with evt_make=0.
REQ-016 Make of an already-held key (typematic repeat) SHALL leave state unchanged and raise no event.
REQ-017 Break of a key not held SHALL raise no event.
REQ-018 Unmapped bytes, including AA/FA/EE/FE, SHALL change no key bit and raise no event; the FSM still follows REQ-013.
REQ-019 key_state, no_press, evt_valid, evt_key and evt_make SHALL be registered; all update on the cycle after the rx_valid cycle (latency 1).
REQ-020 no_press SHALL be consistent with key_state on every cycle.
REQ-021 When clear=1, the block SHALL zero key_state, set no_press=1, force evt_valid=0 and return the FSM to IDLE; clear overrides a simultaneous rx_valid, whose byte is discarded.
REQ-022 evt_key and evt_make SHALL hold their last values while evt_valid=0.

Reset
REQ-023 While resetn=1, outputs SHALL be: key_state=0, no_press=1, evt_valid=0, evt_key=0, evt_make=0, FSM=IDLE; asserting resetn mid-sequence (e.g. after F0) discards the pending prefix.

Configuration
REQ-024 With macro PS2_EXTENDED_EN defined, E0 SHALL enter EXT; the byte following E0 (or following E0 F0) SHALL change no key bit and raise no event.
REQ-025 Without PS2_EXTENDED_EN, E0 SHALL be ignored and the FSM SHALL stay in its current state; the EXT and EXT_BRK states SHALL be absent, so the byte following E0 decodes as an ordinary make or break.

Verification
REQ-026 Reset, then rx 15 -> next cycle key_state[15]=1, no_press=0, evt_valid=1, evt_key=15, evt_make=1.
REQ-027 rx 15, F0, 15 -> after the final byte key_state=0, no_press=1, evt_key=15, evt_make=0; the F0 byte itself raises no event.
REQ-028 rx 29, 29, 29 -> exactly one evt_valid pulse; key_state[28]=1.
REQ-029 rx F0, assert resetn, release, rx 16 -> key_state[1]=1 with evt_make=1.
REQ-030 With PS2_EXTENDED_EN: rx E0 15, E0 F0 15 -> no events, key_state stays 0. Without the macro: the same bytes give a make then a break on index 15.
REQ-031 Hold keys 0 and 28, then clear=1 coincident with rx_valid carrying 16 -> key_state=0, no_press=1, no event, key_state[1] stays 0.

Source files
------------

// File: rtl/ps2_key_decoder_if.sv
// Byte-in / key-event-out bundle for the PS/2 key decoder.
// The master drives the received bytes and clear; the slave reports key state and events.
interface ps2_key_decoder_if #(
  parameter int unsigned NUM_KEYS = 29
);
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                clear;
  logic [NUM_KEYS-1:0] key_state;
  logic                no_press;
  logic                evt_valid;
  logic [4:0]          evt_key;
  logic                evt_make;

  modport master (
    output rx_data, rx_valid, clear,
    input  key_state, no_press, evt_valid, evt_key, evt_make
  );

  modport slave (
    input  rx_data, rx_valid, clear,
    output key_state, no_press, evt_valid, evt_key, evt_make
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// Tracks held keys from a PS/2 scancode byte stream and emits press/release events.
// Define PS2_EXTENDED_EN to swallow E0-prefixed (extended) codes instead of ignoring E0.
module ps2_key_decoder #(
  parameter int unsigned NUM_KEYS = 29
) (
  input logic           CLOCK_50,
  input logic           resetn,
  ps2_key_decoder_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BRK     = 2'd1;
`ifdef PS2_EXTENDED_EN
  localparam logic [1:0] EXT     = 2'd2;
  localparam logic [1:0] EXT_BRK = 2'd3;
`endif

  logic [1:0]          stateQ, stateD;
  logic [NUM_KEYS-1:0] keyStateQ, keyStateD;
  logic                noPressQ;
  logic                evtValidQ, evtValidD;
  logic [4:0]          evtKeyQ, evtKeyD;
  logic                evtMakeQ, evtMakeD;
  logic                hit;
  logic [4:0]          idx;

  // Returns {mapped, index}.
  function automatic logic [5:0] lookupKey(input logic [7:0] code);
    unique case (code)
      8'h0E:   lookupKey = {1'b1, 5'd0};
      8'h16:   lookupKey = {1'b1, 5'd1};
      8'h1E:   lookupKey = {1'b1, 5'd2};
      8'h26:   lookupKey = {1'b1, 5'd3};
      8'h25:   lookupKey = {1'b1, 5'd4};
      8'h2E:   lookupKey = {1'b1, 5'd5};
      8'h36:   lookupKey = {1'b1, 5'd6};
      8'h3D:   lookupKey = {1'b1, 5'd7};
      8'h3E:   lookupKey = {1'b1, 5'd8};
      8'h46:   lookupKey = {1'b1, 5'd9};
      8'h45:   lookupKey = {1'b1, 5'd10};
      8'h4E:   lookupKey = {1'b1, 5'd11};
      8'h55:   lookupKey = {1'b1, 5'd12};
      8'h66:   lookupKey = {1'b1, 5'd13};
      8'h0D:   lookupKey = {1'b1, 5'd14};
      8'h15:   lookupKey = {1'b1, 5'd15};
      8'h1D:   lookupKey = {1'b1, 5'd16};
      8'h24:   lookupKey = {1'b1, 5'd17};
      8'h2D:   lookupKey = {1'b1, 5'd18};
      8'h2C:   lookupKey = {1'b1, 5'd19};
      8'h35:   lookupKey = {1'b1, 5'd20};
      8'h3C:   lookupKey = {1'b1, 5'd21};
      8'h43:   lookupKey = {1'b1, 5'd22};
      8'h44:   lookupKey = {1'b1, 5'd23};
      8'h4D:   lookupKey = {1'b1, 5'd24};
      8'h54:   lookupKey = {1'b1, 5'd25};
      8'h5B:   lookupKey = {1'b1, 5'd26};
      8'h5D:   lookupKey = {1'b1, 5'd27};
      8'h29:   lookupKey = {1'b1, 5'd28};
      default: lookupKey = {1'b0, 5'd0};
    endcase
  endfunction

  assign {hit, idx} = lookupKey(bus.rx_data);

  always_comb begin
    stateD    = stateQ;
    keyStateD = keyStateQ;
    evtValidD = 1'b0;
    evtKeyD   = evtKeyQ;
    evtMakeD  = evtMakeQ;
    if (bus.clear) begin
      stateD    = IDLE;
      keyStateD = '0;
    end else if (bus.rx_valid) begin
      case (stateQ)
        IDLE: begin
          if (bus.rx_data == 8'hF0) begin
            stateD = BRK;
          end else if (bus.rx_data == 8'hE0) begin
`ifdef PS2_EXTENDED_EN
            stateD = EXT;
`endif
          end else if (hit && !keyStateQ[idx]) begin
            keyStateD[idx] = 1'b1;
            evtValidD      = 1'b1;
            evtKeyD        = idx;
            evtMakeD       = 1'b1;
          end
        end
        BRK: begin
          // Without extended support E0 is transparent, so the pending break survives it.
`ifdef PS2_EXTENDED_EN
          if (bus.rx_data != 8'hF0) begin
`else
          if (bus.rx_data != 8'hF0 && bus.rx_data != 8'hE0) begin
`endif
            stateD = IDLE;
            if (hit && keyStateQ[idx]) begin
              keyStateD[idx] = 1'b0;
              evtValidD      = 1'b1;
              evtKeyD        = idx;
              evtMakeD       = 1'b0;
            end
          end
        end
`ifdef PS2_EXTENDED_EN
        EXT:     stateD = (bus.rx_data == 8'hF0) ? EXT_BRK : IDLE;
        EXT_BRK: stateD = IDLE;
`endif
        default: stateD = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge resetn) begin
    if (resetn) begin
      stateQ    <= IDLE;
      keyStateQ <= '0;
      noPressQ  <= 1'b1;
      evtValidQ <= 1'b0;
      evtKeyQ   <= '0;
      evtMakeQ  <= 1'b0;
    end else begin
      stateQ    <= stateD;
      keyStateQ <= keyStateD;
      noPressQ  <= ~|keyStateD;
      evtValidQ <= evtValidD;
      evtKeyQ   <= evtKeyD;
      evtMakeQ  <= evtMakeD;
    end
  end

  assign bus.key_state = keyStateQ;
  assign bus.no_press  = noPressQ;
  assign bus.evt_valid = evtValidQ;
  assign bus.evt_key   = evtKeyQ;
  assign bus.evt_make  = evtMakeQ;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench: directed vector table, hand-written corner sequences,
// then random byte streams compared against a prefix-tracking reference model.
module tb_ps2_key_decoder;

  localparam logic [28:0] B0  = 29'd1;
  localparam logic [28:0] B1  = 29'd1 << 1;
  localparam logic [28:0] B15 = 29'd1 << 15;
  localparam logic [28:0] B28 = 29'd1 << 28;

  logic CLOCK_50 = 1'b0;
  logic resetn;
  int   checks   = 0;
  int   failures = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_key_decoder_if #(.NUM_KEYS(29)) bus ();

  ps2_key_decoder #(.NUM_KEYS(29)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (bus)
  );

  logic [7:0] scanTab [29] = '{
    8'h0E, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
    8'h45, 8'h4E, 8'h55, 8'h66, 8'h0D, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
    8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D, 8'h54, 8'h5B, 8'h5D, 8'h29
  };

  typedef struct {
    logic [7:0]  b;
    logic        expEvt;
    logic [4:0]  expKey;
    logic        expMake;
    logic [28:0] expState;
  } vec_t;

  vec_t vecs [13];

  // Reference model: held-key set plus "break pending" / "extended pending" flags.
  logic [28:0] mKeys;
  bit          mBrk, mExt, mEvt;
  logic [4:0]  mEvtKey;
  logic        mEvtMake;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [7:0] b);
    for (int i = 0; i < 29; i++) if (scanTab[i] == b) return i;
    return -1;
  endfunction

  task automatic modelReset();
    mKeys = '0; mBrk = 0; mExt = 0; mEvt = 0; mEvtKey = '0; mEvtMake = 0;
  endtask

  task automatic modelStep(input logic [7:0] b, input bit clr);
    int k;
    mEvt = 0;
    if (clr) begin
      mKeys = '0; mBrk = 0; mExt = 0;
      return;
    end
`ifdef PS2_EXTENDED_EN
    if (mExt) begin
      if (!mBrk && b == 8'hF0) mBrk = 1;
      else begin mExt = 0; mBrk = 0; end
      return;
    end
    if (b == 8'hE0) begin
      if (mBrk) mBrk = 0;
      else mExt = 1;
      return;
    end
`else
    if (b == 8'hE0) return;
`endif
    if (b == 8'hF0) begin
      mBrk = 1;
      return;
    end
    k = lookup(b);
    if (mBrk) begin
      mBrk = 0;
      if (k >= 0 && mKeys[k]) begin
        mKeys[k] = 1'b0; mEvt = 1; mEvtKey = 5'(k); mEvtMake = 0;
      end
    end else if (k >= 0 && !mKeys[k]) begin
      mKeys[k] = 1'b1; mEvt = 1; mEvtKey = 5'(k); mEvtMake = 1;
    end
  endtask

  // Drives one byte for one cycle; returns at the following falling edge, outputs updated.
  task automatic sendByte(input logic [7:0] b, input logic clr);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    bus.clear    = clr;
    @(negedge CLOCK_50);
    bus.rx_valid = 1'b0;
    bus.clear    = 1'b0;
  endtask

  task automatic gap();
    @(negedge CLOCK_50);
    chk("evt_pulse_width", {31'd0, bus.evt_valid}, 32'd0);
  endtask

  task automatic expectOut(input string tag, input logic evt, input logic [4:0] key,
                           input logic make, input logic [28:0] st);
    chk({tag, ".key_state"}, {3'd0, bus.key_state}, {3'd0, st});
    chk({tag, ".no_press"}, {31'd0, bus.no_press}, {31'd0, (st == '0)});
    chk({tag, ".evt_valid"}, {31'd0, bus.evt_valid}, {31'd0, evt});
    chk({tag, ".evt_key"}, {27'd0, bus.evt_key}, {27'd0, key});
    chk({tag, ".evt_make"}, {31'd0, bus.evt_make}, {31'd0, make});
  endtask

  task automatic doReset();
    resetn = 1'b1;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    expectOut("reset", 1'b0, 5'd0, 1'b0, '0);
    resetn = 1'b0;
    @(negedge CLOCK_50);
    modelReset();
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.clear    = 1'b0;
    resetn       = 1'b1;

    vecs[0]  = '{8'h15, 1'b1, 5'd15, 1'b1, B15};
    vecs[1]  = '{8'hF0, 1'b0, 5'd15, 1'b1, B15};
    vecs[2]  = '{8'h15, 1'b1, 5'd15, 1'b0, '0};
    vecs[3]  = '{8'h29, 1'b1, 5'd28, 1'b1, B28};
    vecs[4]  = '{8'h29, 1'b0, 5'd28, 1'b1, B28};
    vecs[5]  = '{8'h29, 1'b0, 5'd28, 1'b1, B28};
    vecs[6]  = '{8'hAA, 1'b0, 5'd28, 1'b1, B28};
    vecs[7]  = '{8'hF0, 1'b0, 5'd28, 1'b1, B28};
    vecs[8]  = '{8'h16, 1'b0, 5'd28, 1'b1, B28};
    vecs[9]  = '{8'h0E, 1'b1, 5'd0, 1'b1, B28 | B0};
    vecs[10] = '{8'hF0, 1'b0, 5'd0, 1'b1, B28 | B0};
    vecs[11] = '{8'hF0, 1'b0, 5'd0, 1'b1, B28 | B0};
    vecs[12] = '{8'h29, 1'b1, 5'd28, 1'b0, B0};

    @(negedge CLOCK_50);
    doReset();

    for (int i = 0; i < 13; i++) begin
      sendByte(vecs[i].b, 1'b0);
      expectOut($sformatf("vec%0d", i), vecs[i].expEvt, vecs[i].expKey, vecs[i].expMake,
                vecs[i].expState);
      gap();
    end

    // Asynchronous reset mid-break discards the pending F0.
    doReset();
    sendByte(8'hF0, 1'b0);
    #2 resetn = 1'b1;
    @(negedge CLOCK_50);
    expectOut("midreset", 1'b0, 5'd0, 1'b0, '0);
    resetn = 1'b0;
    @(negedge CLOCK_50);
    sendByte(8'h16, 1'b0);
    expectOut("after_midreset", 1'b1, 5'd1, 1'b1, B1);
    gap();

    // Clear beats a coincident byte.
    doReset();
    sendByte(8'h0E, 1'b0); gap();
    sendByte(8'h29, 1'b0);
    expectOut("hold2", 1'b1, 5'd28, 1'b1, B0 | B28);
    gap();
    sendByte(8'h16, 1'b1);
    expectOut("clear", 1'b0, 5'd28, 1'b1, '0);
    gap();
    chk("clear.key1", {31'd0, bus.key_state[1]}, 32'd0);
    // Clear also drops a pending break prefix.
    sendByte(8'hF0, 1'b0); gap();
    bus.clear = 1'b1;
    @(negedge CLOCK_50);
    bus.clear = 1'b0;
    sendByte(8'h16, 1'b0);
    expectOut("clear_prefix", 1'b1, 5'd1, 1'b1, B1);
    gap();

    // E0 handling.
    doReset();
`ifdef PS2_EXTENDED_EN
    sendByte(8'hE0, 1'b0); gap();
    sendByte(8'h15, 1'b0);
    expectOut("ext_make", 1'b0, 5'd0, 1'b0, '0);
    gap();
    sendByte(8'hE0, 1'b0); gap();
    sendByte(8'hF0, 1'b0); gap();
    sendByte(8'h15, 1'b0);
    expectOut("ext_break", 1'b0, 5'd0, 1'b0, '0);
    gap();
    sendByte(8'h16, 1'b0);
    expectOut("ext_after", 1'b1, 5'd1, 1'b1, B1);
    gap();
`else
    sendByte(8'hE0, 1'b0); gap();
    sendByte(8'h15, 1'b0);
    expectOut("e0_make", 1'b1, 5'd15, 1'b1, B15);
    gap();
    sendByte(8'hE0, 1'b0); gap();
    sendByte(8'hF0, 1'b0); gap();
    sendByte(8'h15, 1'b0);
    expectOut("e0_break", 1'b0 | 1'b1, 5'd15, 1'b0, '0);
    gap();
`endif

    // Random streams against the reference model.
    doReset();
    for (int n = 0; n < 600; n++) begin
      logic [7:0] b;
      logic       clr;
      int         r;
      r = $urandom_range(0, 99);
      if (r < 45)      b = scanTab[$urandom_range(0, 28)];
      else if (r < 65) b = 8'hF0;
      else if (r < 75) b = 8'hE0;
      else if (r < 82) begin
        case ($urandom_range(0, 3))
          0:       b = 8'hAA;
          1:       b = 8'hFA;
          2:       b = 8'hEE;
          default: b = 8'hFE;
        endcase
      end else b = 8'($urandom_range(0, 255));
      clr = ($urandom_range(0, 29) == 0);
      modelStep(b, clr);
      sendByte(b, clr);
      expectOut($sformatf("rand%0d_b%02h", n, b), mEvt, mEvtKey, mEvtMake, mKeys);
      gap();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
